phase_monitor: RTL and testbench
================================

# phase_monitor

- Checker stage that sits directly downstream of the four-phase Mealy sequencer.
- Samples the sequencer's 3-bit phase code every enabled cycle and checks it against the only legal orders:
  - long frame: 001→010→011→100
  - short frame: 001→010→100
- Counts completed frames and short frames, and flags the first illegal code seen.
- Feeds status registers and debug logic.

## Interface
Parameters:
- CNT_W, 16, width of frame and short-frame counters (≥2)

Ports:
- clk  input  1  clock
- reset  input  1  reset, asynchronous, active-high
- en  input  1  sample enable; phase_in is ignored when 0
- clr  input  1  synchronous clear of counters and error state
- phase_in  input  3  phase code from upstream sequencer
- in_sync  output  1  monitor is locked to the sequence
- frame_done  output  1  one-cycle pulse per completed frame
- frame_cnt  output  CNT_W  completed frames, saturating
- short_cnt  output  CNT_W  completed short frames (skipped 011), saturating
- err  output  1  sticky error
- err_phase  output  3  code that caused the first error
- last_phase  output  3  last sampled code

## Operation
- FSM states and what each expects next:
  - SYNC: waiting for 001
  - P1: seen 001, expects 010
  - P2: seen 010, expects 011 or 100
  - P3: seen 011, expects 100
  - P4: seen 100, expects 001
- Transitions apply only on edges where en=1.
- SYNC: 001→P1. Any other legal code (010, 011, 100) stays in SYNC with no error.
- P1: 010→P2.
- P2:
  - 011→P3.
  - 100→P4; frame_cnt+1, short_cnt+1, frame_done.
- P3: 100→P4; frame_cnt+1, frame_done.
- P4: 001→P1.
- Any unexpected code in P1–P4 is an error. Codes 000, 101, 110, 111 are errors in every state, including SYNC. On an error:
  - Next state is SYNC.
  - err is set. If err was 0, err_phase captures the offending code.
- in_sync = 1 in P1–P4, 0 in SYNC.
- last_phase updates on every enabled sample.
- Counters hold at all-ones; no wrap.
- clr=1: frame_cnt, short_cnt, err and err_phase go to 0 on that edge. clr does not affect the FSM. A frame completion on the same edge is dropped from the counters, but frame_done still pulses. clr wins over a simultaneous error capture.
- en=0: FSM, last_phase and counters hold; frame_done=0.

## Timing
- All outputs are registered and change only at the clk edge that samples the event, i.e. one cycle of latency from phase_in.
- frame_done is high for exactly the one cycle after the edge that sampled the closing 100.
- Reset values:
  - state SYNC, in_sync 0, frame_done 0
  - frame_cnt 0, short_cnt 0
  - err 0, err_phase 000, last_phase 000
- Reset asserted mid-frame: state returns to SYNC immediately and asynchronously. The next 001 resynchronises with no error.
- Upstream emits 001 on the first cycle after its own reset, so a shared reset locks the monitor on the first enabled edge.

## Configuration
- PHASE_MONITOR_SHORT_CNT_EN
  - Defined: short_cnt counter is implemented as described.
  - Undefined: the short_cnt port remains and is tied to 0, with no counter logic. The FSM and frame_cnt behave the same either way.

## Structure
- Shared package phase_monitor_pkg holds:
  - phase code constants PH_1=3'b001, PH_2=3'b010, PH_3=3'b011, PH_4=3'b100
  - state enum typedef pm_state_t {SYNC, P1, P2, P3, P4}
- One sub-module, sat_counter (parameter W). Ports: clk, reset, clr, inc, count. Synchronous clear with priority, saturating increment. Instantiated for frame_cnt and for short_cnt (only when the macro is defined).

## Test plan
- Reset, en=1, drive 001,010,011,100 repeated 3 times → frame_cnt=3, short_cnt=0, frame_done pulses 3 times, err=0, in_sync=1 from the first edge.
- Drive 001,010,100 repeated twice → frame_cnt=2, short_cnt=2 (0 when the macro is undefined).
- After 001,010, drive 110 → err=1, err_phase=110, in_sync=0. Then drive 011 → no new error, err_phase stays 110. Then a full 001..100 frame → frame_cnt+1.
- CNT_W=2, six long frames → frame_cnt=3 (saturated), frame_done pulses 6 times.
- Assert clr on the edge sampling a closing 100 → frame_cnt=0 and frame_done=1. Assert reset mid-frame after 010 → SYNC; a following 011 gives no error.
- Toggle en=0 for 4 cycles mid-frame with phase_in=111 → no error, state and last_phase hold; the frame completes normally when en returns to 1.

Source files
------------

// File: rtl/phase_monitor_pkg.sv
// Shared types and phase codes for the phase sequence checker.
// Holds the phase constants, the FSM state enum and the per-sample event bundle.
package phase_monitor_pkg;

  localparam logic [2:0] PH_1 = 3'b001;
  localparam logic [2:0] PH_2 = 3'b010;
  localparam logic [2:0] PH_3 = 3'b011;
  localparam logic [2:0] PH_4 = 3'b100;

  typedef enum logic [2:0] {
    SYNC,
    P1,
    P2,
    P3,
    P4
  } pm_state_t;

  typedef struct packed {
    logic done;
    logic bad;
  } pm_event_t;

  function automatic logic is_legal(input logic [2:0] ph);
    logic ok;
    ok = 1'b0;
    unique case (1'b1)
      (ph == PH_1): ok = 1'b1;
      (ph == PH_2): ok = 1'b1;
      (ph == PH_3): ok = 1'b1;
      (ph == PH_4): ok = 1'b1;
      default:      ok = 1'b0;
    endcase
    return ok;
  endfunction

endpackage

// File: rtl/phase_monitor_sat_counter.sv
// Saturating up-counter with synchronous clear taking priority over increment.
// Ports: clk, reset (async, high), clr, inc, count[W-1:0].
module sat_counter #(
  parameter int W = 16
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         clr,
  input  logic         inc,
  output logic [W-1:0] count
);

  localparam logic [W-1:0] ONE = {{(W-1){1'b0}}, 1'b1};

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      count <= '0;
    end else if (clr) begin
      count <= '0;
    end else if (inc && !(&count)) begin
      count <= count + ONE;
    end
  end

endmodule

// File: rtl/phase_monitor.sv
// Checks the 3-bit phase stream against 001-010-011-100 / 001-010-100 frames.
// Ports: clk, reset, en, clr, phase_in[2:0] in; in_sync, frame_done,
// frame_cnt, short_cnt, err, err_phase, last_phase out.
// Macro PHASE_MONITOR_SHORT_CNT_EN enables the short-frame counter.
module phase_monitor
  import phase_monitor_pkg::*;
#(
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             en,
  input  logic             clr,
  input  logic [2:0]       phase_in,
  output logic             in_sync,
  output logic             frame_done,
  output logic [CNT_W-1:0] frame_cnt,
  output logic [CNT_W-1:0] short_cnt,
  output logic             err,
  output logic [2:0]       err_phase,
  output logic [2:0]       last_phase
);

  pm_state_t state;
  pm_state_t nxt;
  pm_event_t ev;

  always_comb begin
    nxt = state;
    ev  = '0;
    unique case (state)
      SYNC: begin
        if (phase_in == PH_1) nxt = P1;
        else if (!is_legal(phase_in)) ev.bad = 1'b1;
      end
      P1: begin
        if (phase_in == PH_2) nxt = P2;
        else ev.bad = 1'b1;
      end
      P2: begin
        if (phase_in == PH_3) begin
          nxt = P3;
        end else if (phase_in == PH_4) begin
          nxt     = P4;
          ev.done = 1'b1;
        end else begin
          ev.bad = 1'b1;
        end
      end
      P3: begin
        if (phase_in == PH_4) begin
          nxt     = P4;
          ev.done = 1'b1;
        end else begin
          ev.bad = 1'b1;
        end
      end
      P4: begin
        if (phase_in == PH_1) nxt = P1;
        else ev.bad = 1'b1;
      end
      default: nxt = SYNC;
    endcase
    if (ev.bad) nxt = SYNC;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state      <= SYNC;
      frame_done <= 1'b0;
      last_phase <= 3'b000;
    end else begin
      frame_done <= en && ev.done;
      if (en) begin
        state      <= nxt;
        last_phase <= phase_in;
      end
    end
  end

  // first-error capture; clr beats an error on the same edge
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      err       <= 1'b0;
      err_phase <= 3'b000;
    end else if (clr) begin
      err       <= 1'b0;
      err_phase <= 3'b000;
    end else if (en && ev.bad) begin
      err <= 1'b1;
      if (!err) err_phase <= phase_in;
    end
  end

  assign in_sync = (state != SYNC);

  sat_counter #(.W(CNT_W)) u_frame_cnt (
    .clk   (clk),
    .reset (reset),
    .clr   (clr),
    .inc   (en && ev.done),
    .count (frame_cnt)
  );

`ifdef PHASE_MONITOR_SHORT_CNT_EN
  logic short_inc;

  assign short_inc = en && (state == P2) && (phase_in == PH_4);

  sat_counter #(.W(CNT_W)) u_short_cnt (
    .clk   (clk),
    .reset (reset),
    .clr   (clr),
    .inc   (short_inc),
    .count (short_cnt)
  );
`else
  assign short_cnt = '0;
`endif

endmodule

// File: tb/tb_phase_monitor.sv
// Scoreboard bench for phase_monitor: a 16-bit and a 2-bit counter instance
// share one stimulus stream; expected outputs are queued per sampled edge.
module tb_phase_monitor;

  logic clk = 1'b0;
  logic reset = 1'b1;
  logic en = 1'b0;
  logic clr = 1'b0;
  logic [2:0] phase_in = 3'b000;

  logic in_sync, frame_done, err;
  logic [15:0] frame_cnt, short_cnt;
  logic [2:0] err_phase, last_phase;

  logic in_sync2, frame_done2, err2;
  logic [1:0] frame_cnt2, short_cnt2;
  logic [2:0] err_phase2, last_phase2;

  always #5 clk = ~clk;

  phase_monitor #(.CNT_W(16)) dut (
    .clk(clk), .reset(reset), .en(en), .clr(clr),
    .phase_in(phase_in), .in_sync(in_sync),
    .frame_done(frame_done), .frame_cnt(frame_cnt),
    .short_cnt(short_cnt), .err(err),
    .err_phase(err_phase), .last_phase(last_phase)
  );

  phase_monitor #(.CNT_W(2)) dut2 (
    .clk(clk), .reset(reset), .en(en), .clr(clr),
    .phase_in(phase_in), .in_sync(in_sync2),
    .frame_done(frame_done2), .frame_cnt(frame_cnt2),
    .short_cnt(short_cnt2), .err(err2),
    .err_phase(err_phase2), .last_phase(last_phase2)
  );

  typedef struct packed {
    logic        in_sync;
    logic        fd;
    logic [15:0] fc;
    logic [15:0] sc;
    logic        err;
    logic [2:0]  ep;
    logic [2:0]  lp;
    logic [1:0]  c2;
    logic [1:0]  s2;
    logic [8:0]  aux;
  } obs_t;

  obs_t exp_q[$];
  obs_t obs_q[$];
  obs_t e, o;

  int n_cmp = 0;
  int n_bad = 0;
  int fd_seen = 0;

  // reference model state
  int          m_st;
  logic        m_fd, m_err;
  logic [15:0] m_fc, m_sc;
  logic [1:0]  m_c2, m_s2;
  logic [2:0]  m_ep, m_lp;

  task automatic model_reset();
    m_st = 0; m_fd = 0; m_err = 0;
    m_fc = 0; m_sc = 0; m_c2 = 0; m_s2 = 0;
    m_ep = 0; m_lp = 0;
  endtask

  function automatic obs_t model_out();
    obs_t r;
    r.in_sync = (m_st != 0);
    r.fd = m_fd;
    r.fc = m_fc;
`ifdef PHASE_MONITOR_SHORT_CNT_EN
    r.sc = m_sc;
    r.s2 = m_s2;
`else
    r.sc = 16'd0;
    r.s2 = 2'd0;
`endif
    r.err = m_err;
    r.ep = m_ep;
    r.lp = m_lp;
    r.c2 = m_c2;
    r.aux = {r.in_sync, m_fd, m_err, m_ep, m_lp};
    return r;
  endfunction

  function automatic obs_t dut_out();
    obs_t r;
    r.in_sync = in_sync;
    r.fd = frame_done;
    r.fc = frame_cnt;
    r.sc = short_cnt;
    r.err = err;
    r.ep = err_phase;
    r.lp = last_phase;
    r.c2 = frame_cnt2;
    r.s2 = short_cnt2;
    r.aux = {in_sync2, frame_done2, err2, err_phase2, last_phase2};
    return r;
  endfunction

  task automatic model_step(input logic [2:0] ph, input logic e_in,
                            input logic c_in);
    logic bad, done, shrt;
    bad = 0; done = 0; shrt = 0;
    m_fd = 0;
    if (e_in) begin
      m_lp = ph;
      if (m_st == 0) begin
        if (ph == 3'd1) m_st = 1;
        else if (!(ph inside {3'd2, 3'd3, 3'd4})) bad = 1;
      end else if (m_st == 1) begin
        if (ph == 3'd2) m_st = 2; else bad = 1;
      end else if (m_st == 2) begin
        if (ph == 3'd3) m_st = 3;
        else if (ph == 3'd4) begin m_st = 4; done = 1; shrt = 1; end
        else bad = 1;
      end else if (m_st == 3) begin
        if (ph == 3'd4) begin m_st = 4; done = 1; end else bad = 1;
      end else begin
        if (ph == 3'd1) m_st = 1; else bad = 1;
      end
      if (bad) begin
        m_st = 0;
        if (!m_err) m_ep = ph;
        m_err = 1;
      end
      m_fd = done;
      if (done && !c_in) begin
        if (m_fc != 16'hFFFF) m_fc++;
        if (m_c2 != 2'b11) m_c2++;
        if (shrt && m_sc != 16'hFFFF) m_sc++;
        if (shrt && m_s2 != 2'b11) m_s2++;
      end
    end
    if (c_in) begin
      m_fc = 0; m_sc = 0; m_c2 = 0; m_s2 = 0;
      m_err = 0; m_ep = 0;
    end
  endtask

  task automatic apply(input logic [2:0] ph, input logic e_in = 1'b1,
                       input logic c_in = 1'b0);
    phase_in = ph;
    en = e_in;
    clr = c_in;
    model_step(ph, e_in, c_in);
    exp_q.push_back(model_out());
    @(posedge clk);
    #1;
    obs_q.push_back(dut_out());
    if (frame_done) fd_seen++;
    en = 1'b0;
    clr = 1'b0;
  endtask

  task automatic long_frame();
    apply(3'd1); apply(3'd2); apply(3'd3); apply(3'd4);
  endtask

  task automatic test_reset();
    model_reset();
    #3;
    n_cmp++;
    if ({in_sync, frame_done, frame_cnt, short_cnt, err, err_phase,
         last_phase} !== '0) begin
      n_bad++;
      $display("FAIL reset_state: got %b want 0",
               {in_sync, frame_done, frame_cnt, short_cnt, err,
                err_phase, last_phase});
    end
    repeat (2) @(posedge clk);
    #1;
    reset = 1'b0;
    #3;
    n_cmp++;
    if (dut_out() !== model_out()) begin
      n_bad++;
      $display("FAIL reset_release: got %h want %h", dut_out(), model_out());
    end
  endtask

  task automatic test_long_frames();
    fd_seen = 0;
    repeat (3) long_frame();
    while (exp_q.size() > 0) begin
      e = exp_q.pop_front(); o = obs_q.pop_front(); n_cmp++;
      if (o !== e) begin
        n_bad++; $display("FAIL long_step: got %h want %h", o, e);
      end
    end
    n_cmp++;
    if (frame_cnt !== 16'd3 || fd_seen != 3 || err !== 1'b0) begin
      n_bad++;
      $display("FAIL long_total: got cnt=%0d pulses=%0d err=%b want 3 3 0",
               frame_cnt, fd_seen, err);
    end
  endtask

  task automatic test_short_frames();
    repeat (2) begin apply(3'd1); apply(3'd2); apply(3'd4); end
    while (exp_q.size() > 0) begin
      e = exp_q.pop_front(); o = obs_q.pop_front(); n_cmp++;
      if (o !== e) begin
        n_bad++; $display("FAIL short_step: got %h want %h", o, e);
      end
    end
    n_cmp++;
`ifdef PHASE_MONITOR_SHORT_CNT_EN
    if (frame_cnt !== 16'd5 || short_cnt !== 16'd2) begin
      n_bad++;
      $display("FAIL short_total: got %0d/%0d want 5/2", frame_cnt, short_cnt);
    end
`else
    if (frame_cnt !== 16'd5 || short_cnt !== 16'd0) begin
      n_bad++;
      $display("FAIL short_total: got %0d/%0d want 5/0", frame_cnt, short_cnt);
    end
`endif
  endtask

  task automatic test_error();
    apply(3'd1); apply(3'd2); apply(3'b110);
    n_cmp++;
    if (err !== 1'b1 || err_phase !== 3'b110 || in_sync !== 1'b0) begin
      n_bad++;
      $display("FAIL err_capture: got err=%b ph=%b sync=%b want 1 110 0",
               err, err_phase, in_sync);
    end
    apply(3'd3);
    long_frame();
    while (exp_q.size() > 0) begin
      e = exp_q.pop_front(); o = obs_q.pop_front(); n_cmp++;
      if (o !== e) begin
        n_bad++; $display("FAIL err_step: got %h want %h", o, e);
      end
    end
    n_cmp++;
    if (frame_cnt !== 16'd6 || err_phase !== 3'b110) begin
      n_bad++;
      $display("FAIL err_after: got cnt=%0d ph=%b want 6 110",
               frame_cnt, err_phase);
    end
  endtask

  task automatic test_saturation();
    apply(3'd0, 1'b0, 1'b1);
    fd_seen = 0;
    repeat (6) long_frame();
    while (exp_q.size() > 0) begin
      e = exp_q.pop_front(); o = obs_q.pop_front(); n_cmp++;
      if (o !== e) begin
        n_bad++; $display("FAIL sat_step: got %h want %h", o, e);
      end
    end
    n_cmp++;
    if (frame_cnt2 !== 2'd3 || fd_seen != 6 || frame_cnt !== 16'd6) begin
      n_bad++;
      $display("FAIL sat_total: got c2=%0d pulses=%0d c16=%0d want 3 6 6",
               frame_cnt2, fd_seen, frame_cnt);
    end
  endtask

  task automatic test_clr_close();
    apply(3'd1); apply(3'd2); apply(3'd3);
    apply(3'd4, 1'b1, 1'b1);
    n_cmp++;
    if (frame_cnt !== 16'd0 || frame_done !== 1'b1) begin
      n_bad++;
      $display("FAIL clr_close: got cnt=%0d done=%b want 0 1",
               frame_cnt, frame_done);
    end
    while (exp_q.size() > 0) begin
      e = exp_q.pop_front(); o = obs_q.pop_front(); n_cmp++;
      if (o !== e) begin
        n_bad++; $display("FAIL clr_step: got %h want %h", o, e);
      end
    end
  endtask

  task automatic test_reset_midframe();
    apply(3'd1); apply(3'd2);
    #2;
    reset = 1'b1;
    model_reset();
    #2;
    n_cmp++;
    if (in_sync !== 1'b0) begin
      n_bad++;
      $display("FAIL async_reset: got sync=%b want 0", in_sync);
    end
    reset = 1'b0;
    apply(3'd3);
    n_cmp++;
    if (err !== 1'b0 || in_sync !== 1'b0) begin
      n_bad++;
      $display("FAIL reset_resync: got err=%b sync=%b want 0 0", err, in_sync);
    end
    apply(3'd1);
    while (exp_q.size() > 0) begin
      e = exp_q.pop_front(); o = obs_q.pop_front(); n_cmp++;
      if (o !== e) begin
        n_bad++; $display("FAIL rst_step: got %h want %h", o, e);
      end
    end
  endtask

  task automatic test_enable_hold();
    fd_seen = 0;
    apply(3'd2);
    repeat (4) apply(3'b111, 1'b0);
    n_cmp++;
    if (err !== 1'b0 || last_phase !== 3'd2 || in_sync !== 1'b1) begin
      n_bad++;
      $display("FAIL en_hold: got err=%b lp=%b sync=%b want 0 010 1",
               err, last_phase, in_sync);
    end
    apply(3'd3); apply(3'd4);
    while (exp_q.size() > 0) begin
      e = exp_q.pop_front(); o = obs_q.pop_front(); n_cmp++;
      if (o !== e) begin
        n_bad++; $display("FAIL en_step: got %h want %h", o, e);
      end
    end
    n_cmp++;
    if (frame_cnt !== 16'd1 || fd_seen != 1) begin
      n_bad++;
      $display("FAIL en_total: got cnt=%0d pulses=%0d want 1 1",
               frame_cnt, fd_seen);
    end
  endtask

  initial begin
    test_reset();
    test_long_frames();
    test_short_frames();
    test_error();
    test_saturation();
    test_clr_close();
    test_reset_midframe();
    test_enable_hold();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
